// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared CPU widths and write-back arbiter state encoding   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package cpu_pkg;

    localparam int C_WIDTH_DEFAULT = 32;
    localparam int C_ADDR_WIDTH    = $clog2(C_WIDTH_DEFAULT);
    localparam int C_CNT_WIDTH     = 4;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        FORCE_MC = 1'b1
    } wb_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux : generic N-way, W-bit selector; input slot k chosen by sel = k |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mux #(
    parameter int W = 32,
    parameter int N = 2,
    localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0][W-1:0]   data_in,
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic [W-1:0]          data_out
);

    assign data_out = data_in[sel];

endmodule : mux
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_arbiter : shares the register-file write port between pipeline   |
// | step 5 and a multi-cycle unit, with starvation-forced mc grants.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int  WIDTH        = C_WIDTH_DEFAULT,
    parameter int  STARVE_LIMIT = 4,
    localparam int ADDR_WIDTH   = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic                  pipe_is_load,
    input  logic [ADDR_WIDTH-1:0] pipe_rd,
    input  logic [WIDTH-1:0]      pipe_alu,
    input  logic [WIDTH-1:0]      pipe_mem,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [ADDR_WIDTH-1:0] mc_rd,
    input  logic [WIDTH-1:0]      mc_data,
    output logic                  stall_pipe,
    output logic                  control_mux_for_write_back,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata
);

    localparam logic [C_CNT_WIDTH-1:0] C_LIMIT = C_CNT_WIDTH'(STARVE_LIMIT);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
            $error("wb_arbiter: STARVE_LIMIT must be within 1..15");
        end
    endgenerate

    wb_state_e              r_state;
    wb_state_e              w_state_next;
    logic [C_CNT_WIDTH-1:0] r_cnt;
    logic [C_CNT_WIDTH-1:0] w_cnt_next;
    logic                   w_mc_ready;
    logic                   w_stall;
    logic                   w_mc_xfer;
    logic                   w_pipe_grant;
    logic [WIDTH-1:0]       w_pipe_data;

    assign control_mux_for_write_back = !pipe_is_load;

    mux #(
        .W (WIDTH),
        .N (2)
    ) u_pipe_mux (
        .data_in  ({pipe_alu, pipe_mem}),
        .sel      (control_mux_for_write_back),
        .data_out (w_pipe_data)
    );

    always_comb begin
        w_mc_ready   = 1'b0;
        w_stall      = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;

        // Handshake outputs stay quiet while reset is asserted.
        if (rst) begin
            case (r_state)
                NORMAL:   w_mc_ready = !pipe_valid;
                FORCE_MC: begin
                    w_mc_ready = 1'b1;
                    w_stall    = 1'b1;
                end
                default:  w_mc_ready = 1'b0;
            endcase
        end

        w_mc_xfer    = mc_valid && w_mc_ready;
        w_pipe_grant = rst && pipe_valid && (r_state == NORMAL);

        if (!mc_valid || w_mc_xfer) begin
            w_cnt_next = '0;
        end else if (r_cnt < C_LIMIT) begin
            w_cnt_next = r_cnt + 1'b1;
        end

        // Force on the edge where the wait count reaches the limit, so the
        // mc unit loses exactly STARVE_LIMIT arbitrations before winning.
        case (r_state)
            NORMAL:   if (mc_valid && (w_cnt_next == C_LIMIT)) w_state_next = FORCE_MC;
            FORCE_MC: w_state_next = NORMAL;
            default:  w_state_next = NORMAL;
        endcase
    end

    assign mc_ready   = w_mc_ready;
    assign stall_pipe = w_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= NORMAL;
            r_cnt    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_pipe_grant) begin
                rf_we    <= (pipe_rd != '0);
                rf_waddr <= pipe_rd;
                rf_wdata <= w_pipe_data;
            end else if (w_mc_xfer) begin
                rf_we    <= (mc_rd != '0);
                rf_waddr <= mc_rd;
                rf_wdata <= mc_data;
            end else begin
                rf_we    <= 1'b0;
            end
        end
    end

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_arbiter : directed + random bench against a behavioural model |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_wb_arbiter;

    localparam int WIDTH        = 32;
    localparam int ADDR_WIDTH   = 5;
    localparam int STARVE_LIMIT = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pipe_valid;
    logic                  pipe_is_load;
    logic [ADDR_WIDTH-1:0] pipe_rd;
    logic [WIDTH-1:0]      pipe_alu;
    logic [WIDTH-1:0]      pipe_mem;
    logic                  mc_valid;
    logic                  mc_ready;
    logic [ADDR_WIDTH-1:0] mc_rd;
    logic [WIDTH-1:0]      mc_data;
    logic                  stall_pipe;
    logic                  control_mux_for_write_back;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [WIDTH-1:0]      rf_wdata;

    wb_arbiter #(
        .WIDTH        (WIDTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .pipe_valid                 (pipe_valid),
        .pipe_is_load               (pipe_is_load),
        .pipe_rd                    (pipe_rd),
        .pipe_alu                   (pipe_alu),
        .pipe_mem                   (pipe_mem),
        .mc_valid                   (mc_valid),
        .mc_ready                   (mc_ready),
        .mc_rd                      (mc_rd),
        .mc_data                    (mc_data),
        .stall_pipe                 (stall_pipe),
        .control_mux_for_write_back (control_mux_for_write_back),
        .rf_we                      (rf_we),
        .rf_waddr                   (rf_waddr),
        .rf_wdata                   (rf_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: how long the mc unit has been refused, whether the
    // next cycle is a forced mc slot, and the write expected on the port.
    int                    m_wait   = 0;
    bit                    m_forced = 1'b0;
    bit                    m_xfer   = 1'b0;
    logic                  m_we     = 1'b0;
    logic [ADDR_WIDTH-1:0] m_waddr  = '0;
    logic [WIDTH-1:0]      m_wdata  = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs are already applied (just after a negedge); checks the
    // combinational outputs, clocks once, then checks the write port.
    task automatic step(input string tag);
        logic exp_rdy, exp_stall, pipe_win;
        bit   next_forced;
        #1;
        exp_rdy   = rst && (m_forced || !pipe_valid);
        exp_stall = rst && m_forced;
        check_val({tag, ".mc_ready"}, mc_ready, exp_rdy);
        check_val({tag, ".stall"}, stall_pipe, exp_stall);
        check_val({tag, ".mux"}, control_mux_for_write_back, !pipe_is_load);

        @(posedge clk);
        if (!rst) begin
            m_wait = 0; m_forced = 1'b0; m_xfer = 1'b0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_xfer   = mc_valid && exp_rdy;
            pipe_win = pipe_valid && !m_forced;
            if (pipe_win) begin
                m_we = (pipe_rd != 0); m_waddr = pipe_rd;
                m_wdata = pipe_is_load ? pipe_mem : pipe_alu;
            end else if (m_xfer) begin
                m_we = (mc_rd != 0); m_waddr = mc_rd; m_wdata = mc_data;
            end else begin
                m_we = 1'b0;
            end
            if (!mc_valid || m_xfer) m_wait = 0;
            else if (m_wait < STARVE_LIMIT) m_wait++;
            next_forced = !m_forced && mc_valid && (m_wait == STARVE_LIMIT);
            m_forced = next_forced;
        end

        @(negedge clk);
        check_val({tag, ".we"}, rf_we, m_we);
        check_val({tag, ".waddr"}, rf_waddr, m_waddr);
        check_val({tag, ".wdata"}, rf_wdata, m_wdata);
    endtask

    initial begin
        rst = 1'b0; pipe_valid = 1'b0; pipe_is_load = 1'b0; pipe_rd = '0;
        pipe_alu = '0; pipe_mem = '0; mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h77;
        @(negedge clk);

        // Reset held with a pending mc result
        step("rst0");
        step("rst1");
        check_val("rst.we", rf_we, 1'b0);
        check_val("rst.waddr", rf_waddr, 0);
        rst = 1'b1; mc_valid = 1'b0;
        step("idle");

        // ALU write to r7
        pipe_valid = 1'b1; pipe_is_load = 1'b0; pipe_rd = 5'd7; pipe_alu = 32'hAA;
        step("alu");
        check_val("alu.we_const", rf_we, 1'b1);
        check_val("alu.wdata_const", rf_wdata, 32'hAA);

        // Load to x0 must not write
        pipe_is_load = 1'b1; pipe_rd = 5'd0; pipe_mem = 32'h1234;
        step("ld_x0");
        check_val("ld_x0.we_const", rf_we, 1'b0);
        check_val("ld_x0.wdata_const", rf_wdata, 32'h1234);

        // Idle pipeline: mc granted immediately
        pipe_valid = 1'b0; mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h55;
        #1 check_val("mc_idle.ready_const", mc_ready, 1'b1);
        step("mc_idle");
        check_val("mc_idle.waddr_const", rf_waddr, 5'd3);
        mc_valid = 1'b0;

        // Starvation: four pipe writes, one forced slot, then the mc write
        pipe_valid = 1'b1; pipe_is_load = 1'b0; mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'hD1;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            pipe_rd = 5'(10 + i); pipe_alu = 32'(i + 1);
            step("starve");
            check_val("starve.pipe_addr", rf_waddr, 5'(10 + i));
        end
        #1 check_val("starve.stall_const", stall_pipe, 1'b1);
        step("force");
        check_val("force.mc_addr", rf_waddr, 5'd9);
        check_val("force.mc_data", rf_wdata, 32'hD1);
        mc_valid = 1'b0;
        step("post_force");

        // Reset during the forced slot drops the grant
        mc_valid = 1'b1; mc_rd = 5'd12; mc_data = 32'hBEEF;
        for (int i = 0; i < STARVE_LIMIT; i++) step("starve2");
        rst = 1'b0;
        step("rst_force");
        check_val("rst_force.we_const", rf_we, 1'b0);
        rst = 1'b1;
        #1 check_val("rearb.ready_const", mc_ready, 1'b0);
        step("rearb_pipe");
        pipe_valid = 1'b0;
        step("rearb_mc");
        check_val("rearb.mc_addr", rf_waddr, 5'd12);
        mc_valid = 1'b0;

        // Random traffic; mc request held stable until it transfers
        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(0, 49) != 0);
            pipe_valid   = ($urandom_range(0, 3) != 0);
            pipe_is_load = $urandom_range(0, 1) != 0;
            pipe_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pipe_alu     = $urandom;
            pipe_mem     = $urandom;
            if (!mc_valid || m_xfer) begin
                mc_valid = ($urandom_range(0, 2) != 0);
                mc_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                mc_data  = $urandom;
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of the register-file write port.
REQ-002 Parameter STARVE_LIMIT, default 4: multi-cycle-unit wait cycles before forced grant; legal range 1..15.
REQ-003 Localparam ADDR_WIDTH = $clog2(WIDTH): register address width (5 at default).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 pipe_valid  in  1  step-5 instruction requests write-back this cycle.
REQ-007 pipe_is_load  in  1  step-5 result comes from memory (1) or ALU (0).
REQ-008 pipe_rd  in  ADDR_WIDTH  step-5 destination register.
REQ-009 pipe_alu  in  WIDTH  ALU result from step 5.
REQ-010 pipe_mem  in  WIDTH  memory result from step 5.
REQ-011 mc_valid  in  1  multi-cycle unit (divider) holds a result.
REQ-012 mc_ready  out  1  arbiter accepts mc result this cycle.
REQ-013 mc_rd  in  ADDR_WIDTH  mc destination register.
REQ-014 mc_data  in  WIDTH  mc result.
REQ-015 stall_pipe  out  1  freeze step 5 and earlier stages.
REQ-016 control_mux_for_write_back  out  1  write-back mux select; 1 = ALU, 0 = memory.
REQ-017 rf_we / rf_waddr / rf_wdata  out  1 / ADDR_WIDTH / WIDTH  registered register-file write port.

Function
REQ-018 FSM states: NORMAL, FORCE_MC; reset state NORMAL.
REQ-019 control_mux_for_write_back SHALL be combinational: !pipe_is_load.
REQ-020 NORMAL: mc_ready = !pipe_valid; stall_pipe = 0; pipe write-back has priority.
REQ-021 FORCE_MC: mc_ready = 1; stall_pipe = 1; no pipe write-back is performed that cycle.
REQ-022 Handshake: mc transfer occurs when mc_valid && mc_ready; mc_valid, mc_rd and mc_data are stable from assertion until transfer.
REQ-023 Wait counter (4 bits): increments when mc_valid && !mc_ready, saturating at STARVE_LIMIT; clears on any mc transfer or when mc_valid = 0.
REQ-024 NORMAL -> FORCE_MC when counter == STARVE_LIMIT and mc_valid = 1 at the clock edge; FORCE_MC -> NORMAL after exactly one cycle, whether or not a transfer occurred.
REQ-025 Write port latency is one cycle: the granted source's rd/data appear on rf_waddr/rf_wdata with rf_we = 1 on the following cycle.
REQ-026 Pipe grant data = pipe_is_load ? pipe_mem : pipe_alu.
REQ-027 rf_we SHALL be 0 whenever the granted destination is register 0; rf_waddr/rf_wdata still update.
REQ-028 No grant in a cycle -> rf_we = 0 next cycle; rf_waddr/rf_wdata hold their previous values.
REQ-029 pipe_valid and mc_valid both high in NORMAL with counter < STARVE_LIMIT -> pipe wins and counter increments.
REQ-030 At most one register-file write per cycle under all input combinations.

Reset
REQ-031 rst = 0 at a rising edge -> state NORMAL, counter 0, rf_we 0, rf_waddr 0, rf_wdata 0.
REQ-032 Reset during FORCE_MC discards the pending forced grant; no write occurs on the cycle following reset.
REQ-033 While rst = 0: mc_ready = 0 and stall_pipe = 0.

Structure
REQ-034 WIDTH default, ADDR_WIDTH, and the FSM state enum SHALL live in shared package cpu_pkg.
REQ-035 Pipe data select SHALL use one instance of the existing mux (W = WIDTH, N = 2, inputs {pipe_alu, pipe_mem}), driven by control_mux_for_write_back.
REQ-036 Counter, FSM and output registers SHALL be inline in wb_arbiter; no other sub-modules.

Verification
REQ-037 Reset: rst = 0 for 2 cycles with mc_valid = 1 -> rf_we = 0, mc_ready = 0, stall_pipe = 0, counter 0.
REQ-038 ALU write: pipe_valid = 1, pipe_is_load = 0, rd = 7, alu = 0x0000_00AA -> next cycle rf_we = 1, waddr = 7, wdata = 0xAA, mux select = 1.
REQ-039 Load to x0: pipe_valid = 1, pipe_is_load = 1, rd = 0, mem = 0x1234 -> mux select = 0, rf_we = 0 next cycle.
REQ-040 Idle mc grant: pipe_valid = 0, mc_valid = 1, rd = 3, data = 0x55 -> mc_ready = 1 same cycle; next cycle write of 0x55 to r3.
REQ-041 Starvation: pipe_valid held 1, mc_valid held 1, STARVE_LIMIT = 4 -> 4 pipe writes, then 1 cycle with stall_pipe = 1 and mc_ready = 1, mc write follows, counter 0.
REQ-042 Reset mid FORCE_MC: rst = 0 during the stall cycle -> no mc write, state NORMAL, mc_valid still high and re-arbitrated normally.
